// File: rtl/acs_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : acs_scheduler
// Purpose  : Time-multiplexes one ACS unit over all Viterbi trellis states,
//            one target state per cycle. Owns the double-buffered path
//            metrics and reachability flags, collects survivor decisions,
//            reports the best state and renormalises metrics.
// Revision : 1.0  initial release
// ============================================================================
module acs_scheduler #(
   parameter int NUM_STATES = 8,
   parameter int SW         = $clog2(NUM_STATES),
   parameter int PM_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init_i,
   input  logic                  sym_valid_i,
   output logic                  sym_ready_o,
   output logic [SW-1:0]         acs_state_o,
   output logic [PM_W-1:0]       acs_path_0_pmc_o,
   output logic [PM_W-1:0]       acs_path_1_pmc_o,
   output logic                  acs_path_0_valid_o,
   output logic                  acs_path_1_valid_o,
   input  logic                  acs_selection_i,
   input  logic                  acs_valid_i,
   input  logic [PM_W-1:0]       acs_path_cost_i,
   output logic                  dec_valid_o,
   output logic [NUM_STATES-1:0] dec_bits_o,
   output logic [NUM_STATES-1:0] dec_mask_o,
   output logic [SW-1:0]         best_state_o,
   output logic [PM_W-1:0]       best_cost_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   localparam logic [PM_W-1:0]       c_HALF       = {1'b1, {(PM_W-1){1'b0}}};
   localparam logic [SW-1:0]         c_LAST_IDX   = SW'(NUM_STATES - 1);
   localparam logic [NUM_STATES-1:0] c_INIT_VALID = {{(NUM_STATES-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [SW-1:0]         idx_q, idx_d;
   logic                  ready_q, ready_d;
   logic [PM_W-1:0]       pm_cur_q [NUM_STATES];
   logic [PM_W-1:0]       pm_cur_d [NUM_STATES];
   logic [PM_W-1:0]       pm_nxt_q [NUM_STATES];
   logic [PM_W-1:0]       pm_nxt_d [NUM_STATES];
   logic [NUM_STATES-1:0] valid_cur_q, valid_cur_d;
   logic [NUM_STATES-1:0] valid_nxt_q, valid_nxt_d;
   logic [NUM_STATES-1:0] sel_q, sel_d;
   logic [PM_W-1:0]       min_cost_q, min_cost_d;
   logic [SW-1:0]         min_state_q, min_state_d;
   logic                  min_found_q, min_found_d;
   logic                  dec_valid_q, dec_valid_d;
   logic [NUM_STATES-1:0] dec_bits_q, dec_bits_d;
   logic [NUM_STATES-1:0] dec_mask_q, dec_mask_d;
   logic [SW-1:0]         best_state_q, best_state_d;
   logic [PM_W-1:0]       best_cost_q, best_cost_d;

   logic [SW-1:0]         w_p0, w_p1;
   logic                  w_accept;
   logic                  w_norm;

   // Predecessors of state i are 2i and 2i+1 modulo NUM_STATES: drop the MSB and shift.
   assign w_p0     = {idx_q[SW-2:0], 1'b0};
   assign w_p1     = {idx_q[SW-2:0], 1'b1};
   assign w_accept = (state_q == ST_IDLE) && ready_q && sym_valid_i;
   assign w_norm   = min_found_q && (min_cost_q >= c_HALF);

   assign sym_ready_o  = ready_q;
   // An abort during EMIT suppresses the strobe that would otherwise escape that cycle.
   assign dec_valid_o  = dec_valid_q & ~init_i;
   assign dec_bits_o   = dec_bits_q;
   assign dec_mask_o   = dec_mask_q;
   assign best_state_o = best_state_q;
   assign best_cost_o  = best_cost_q;

   // Next-state, buffer updates and ACS operand drive.
   always_comb begin
      state_d            = state_q;
      idx_d              = idx_q;
      pm_cur_d           = pm_cur_q;
      pm_nxt_d           = pm_nxt_q;
      valid_cur_d        = valid_cur_q;
      valid_nxt_d        = valid_nxt_q;
      sel_d              = sel_q;
      min_cost_d         = min_cost_q;
      min_state_d        = min_state_q;
      min_found_d        = min_found_q;
      dec_valid_d        = 1'b0;
      dec_bits_d         = dec_bits_q;
      dec_mask_d         = dec_mask_q;
      best_state_d       = best_state_q;
      best_cost_d        = best_cost_q;
      acs_state_o        = '0;
      acs_path_0_pmc_o   = '0;
      acs_path_1_pmc_o   = '0;
      acs_path_0_valid_o = 1'b0;
      acs_path_1_valid_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               state_d     = ST_RUN;
               idx_d       = '0;
               min_found_d = 1'b0;
               min_cost_d  = '0;
               min_state_d = '0;
               sel_d       = '0;
               valid_nxt_d = '0;
            end
         end
         ST_RUN: begin
            acs_state_o        = idx_q;
            acs_path_0_pmc_o   = pm_cur_q[w_p0];
            acs_path_1_pmc_o   = pm_cur_q[w_p1];
            acs_path_0_valid_o = valid_cur_q[w_p0];
            acs_path_1_valid_o = valid_cur_q[w_p1];
            pm_nxt_d[idx_q]    = acs_path_cost_i;
            valid_nxt_d[idx_q] = acs_valid_i;
            sel_d[idx_q]       = acs_selection_i & acs_valid_i;
            // Strict compare with ascending index keeps the lower index on ties.
            if (acs_valid_i && (!min_found_q || (acs_path_cost_i < min_cost_q))) begin
               min_found_d = 1'b1;
               min_cost_d  = acs_path_cost_i;
               min_state_d = idx_q;
            end
            if (idx_q == c_LAST_IDX) begin
               // Decision outputs are loaded here so they are stable during EMIT.
               state_d     = ST_EMIT;
               dec_valid_d = 1'b1;
               dec_bits_d  = sel_d;
               dec_mask_d  = valid_nxt_d;
               if (min_found_d) begin
                  best_state_d = min_state_d;
                  best_cost_d  = (min_cost_d >= c_HALF) ? (min_cost_d - c_HALF) : min_cost_d;
               end else begin
                  best_state_d = '0;
                  best_cost_d  = '0;
               end
            end else begin
               idx_d = idx_q + SW'(1);
            end
         end
         ST_EMIT: begin
            state_d = ST_IDLE;
            if (!min_found_q) begin
               // Nothing reachable: restart from the frame-start pattern.
               for (int s = 0; s < NUM_STATES; s++) begin
                  pm_cur_d[s] = '0;
               end
               valid_cur_d = c_INIT_VALID;
            end else begin
               for (int s = 0; s < NUM_STATES; s++) begin
                  pm_cur_d[s] = (w_norm && valid_nxt_q[s]) ? (pm_nxt_q[s] - c_HALF) : pm_nxt_q[s];
               end
               valid_cur_d = valid_nxt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Frame restart wins over everything, including a simultaneous symbol.
      if (init_i) begin
         state_d     = ST_IDLE;
         idx_d       = '0;
         for (int s = 0; s < NUM_STATES; s++) begin
            pm_cur_d[s] = '0;
         end
         valid_cur_d  = c_INIT_VALID;
         valid_nxt_d  = '0;
         sel_d        = '0;
         min_found_d  = 1'b0;
         min_cost_d   = '0;
         min_state_d  = '0;
         dec_valid_d  = 1'b0;
         dec_bits_d   = dec_bits_q;
         dec_mask_d   = dec_mask_q;
         best_state_d = best_state_q;
         best_cost_d  = best_cost_q;
      end

      ready_d = (state_d == ST_IDLE);
   end

   // State and storage registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         ready_q      <= 1'b0;
         for (int s = 0; s < NUM_STATES; s++) begin
            pm_cur_q[s] <= '0;
            pm_nxt_q[s] <= '0;
         end
         valid_cur_q  <= c_INIT_VALID;
         valid_nxt_q  <= '0;
         sel_q        <= '0;
         min_cost_q   <= '0;
         min_state_q  <= '0;
         min_found_q  <= 1'b0;
         dec_valid_q  <= 1'b0;
         dec_bits_q   <= '0;
         dec_mask_q   <= '0;
         best_state_q <= '0;
         best_cost_q  <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         ready_q      <= ready_d;
         pm_cur_q     <= pm_cur_d;
         pm_nxt_q     <= pm_nxt_d;
         valid_cur_q  <= valid_cur_d;
         valid_nxt_q  <= valid_nxt_d;
         sel_q        <= sel_d;
         min_cost_q   <= min_cost_d;
         min_state_q  <= min_state_d;
         min_found_q  <= min_found_d;
         dec_valid_q  <= dec_valid_d;
         dec_bits_q   <= dec_bits_d;
         dec_mask_q   <= dec_mask_d;
         best_state_q <= best_state_d;
         best_cost_q  <= best_cost_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_acs_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_acs_scheduler
// Purpose  : Self-checking bench for acs_scheduler. The bench plays the ACS
//            unit and keeps a symbol-level reference model of the trellis.
// Revision : 1.0  initial release
// ============================================================================
module tb_acs_scheduler;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         init_i;
   logic         sym_valid_i;
   logic         sym_ready_o;
   logic [2:0]   acs_state_o;
   logic [7:0]   acs_path_0_pmc_o;
   logic [7:0]   acs_path_1_pmc_o;
   logic         acs_path_0_valid_o;
   logic         acs_path_1_valid_o;
   logic         acs_selection_i;
   logic         acs_valid_i;
   logic [7:0]   acs_path_cost_i;
   logic         dec_valid_o;
   logic [7:0]   dec_bits_o;
   logic [7:0]   dec_mask_o;
   logic [2:0]   best_state_o;
   logic [7:0]   best_cost_o;

   int errors = 0;
   int checks = 0;

   // Branch metrics for the symbol in flight, per target state.
   logic [7:0] bm0 [N];
   logic [7:0] bm1 [N];

   // Reference model: current metrics/reachability and expected symbol result.
   int m_pm [N];
   bit m_v  [N];
   int e_pm [N];
   bit e_v  [N];
   bit e_sel [N];
   logic [7:0] e_bits, e_mask;
   int e_best_state, e_best_cost;

   acs_scheduler #(.NUM_STATES(8), .PM_W(8)) dut (
      .clk                (clk),
      .rst                (rst),
      .init_i             (init_i),
      .sym_valid_i        (sym_valid_i),
      .sym_ready_o        (sym_ready_o),
      .acs_state_o        (acs_state_o),
      .acs_path_0_pmc_o   (acs_path_0_pmc_o),
      .acs_path_1_pmc_o   (acs_path_1_pmc_o),
      .acs_path_0_valid_o (acs_path_0_valid_o),
      .acs_path_1_valid_o (acs_path_1_valid_o),
      .acs_selection_i    (acs_selection_i),
      .acs_valid_i        (acs_valid_i),
      .acs_path_cost_i    (acs_path_cost_i),
      .dec_valid_o        (dec_valid_o),
      .dec_bits_o         (dec_bits_o),
      .dec_mask_o         (dec_mask_o),
      .best_state_o       (best_state_o),
      .best_cost_o        (best_cost_o)
   );

   initial forever #5 clk = ~clk;

   // Behavioural ACS unit: add-compare-select, ties go to path 0.
   logic [7:0] c0, c1;
   always_comb begin
      c0              = acs_path_0_pmc_o + bm0[acs_state_o];
      c1              = acs_path_1_pmc_o + bm1[acs_state_o];
      acs_valid_i     = acs_path_0_valid_o | acs_path_1_valid_o;
      acs_selection_i = acs_path_1_valid_o && (!acs_path_0_valid_o || (c1 < c0));
      acs_path_cost_i = !acs_valid_i ? 8'd0 : (acs_selection_i ? c1 : c0);
   end

   function automatic void model_init();
      for (int s = 0; s < N; s++) begin
         m_pm[s] = 0;
         m_v[s]  = (s == 0);
      end
   endfunction

   // Expected outcome of one symbol, from the trellis rules on whole arrays.
   function automatic void model_compute();
      int  mn;
      bit  found;
      found = 0;
      mn    = 0;
      e_best_state = 0;
      for (int s = 0; s < N; s++) begin
         int a, b, ca, cb;
         a  = (2 * s) % N;
         b  = (2 * s + 1) % N;
         ca = m_pm[a] + int'(bm0[s]);
         cb = m_pm[b] + int'(bm1[s]);
         e_v[s] = m_v[a] | m_v[b];
         if (!e_v[s]) begin
            e_sel[s] = 0;
            e_pm[s]  = 0;
         end else begin
            e_sel[s] = (m_v[a] && m_v[b]) ? (cb < ca) : m_v[b];
            e_pm[s]  = e_sel[s] ? cb : ca;
            if (!found || e_pm[s] < mn) begin
               found = 1;
               mn = e_pm[s];
               e_best_state = s;
            end
         end
         e_bits[s] = e_sel[s];
         e_mask[s] = e_v[s];
      end
      if (!found) begin
         e_best_state = 0;
         e_best_cost  = 0;
         for (int s = 0; s < N; s++) begin
            e_pm[s] = 0;
            e_v[s]  = (s == 0);
         end
      end else if (mn >= 128) begin
         e_best_cost = mn - 128;
         for (int s = 0; s < N; s++) if (e_v[s]) e_pm[s] -= 128;
      end else begin
         e_best_cost = mn;
      end
   endfunction

   function automatic void model_commit();
      for (int s = 0; s < N; s++) begin
         m_pm[s] = e_pm[s];
         m_v[s]  = e_v[s];
      end
   endfunction

   function automatic void set_bm(input int v);
      for (int s = 0; s < N; s++) begin
         bm0[s] = 8'(v);
         bm1[s] = 8'(v);
      end
   endfunction

   // Runs one symbol, checking every RUN cycle and the EMIT result.
   // abort_cycle in 1..8 asserts init_i on that RUN cycle instead.
   task automatic do_symbol(input int abort_cycle);
      int wait_n;
      int a, b;
      wait_n = 0;
      model_compute();
      while (sym_ready_o !== 1'b1 && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      checks++;
      if (wait_n >= 50) begin
         errors++;
         $display("FAIL ready_timeout: sym_ready_o=%b required 1", sym_ready_o);
      end
      sym_valid_i = 1'b1;
      @(negedge clk);
      sym_valid_i = 1'b0;
      for (int c = 1; c <= N; c++) begin
         a = (2 * (c - 1)) % N;
         b = (2 * (c - 1) + 1) % N;
         checks++;
         if (acs_state_o !== 3'(c - 1)) begin
            errors++;
            $display("FAIL acs_state cycle %0d: got %0d required %0d", c, acs_state_o, c - 1);
         end
         checks++;
         if (acs_path_0_valid_o !== m_v[a] || acs_path_1_valid_o !== m_v[b]) begin
            errors++;
            $display("FAIL pred_valid state %0d: got %b%b required %b%b", c - 1,
                     acs_path_0_valid_o, acs_path_1_valid_o, m_v[a], m_v[b]);
         end
         if (m_v[a]) begin
            checks++;
            if (int'(acs_path_0_pmc_o) !== m_pm[a]) begin
               errors++;
               $display("FAIL pmc0 state %0d: got %0d required %0d", c - 1, acs_path_0_pmc_o, m_pm[a]);
            end
         end
         if (m_v[b]) begin
            checks++;
            if (int'(acs_path_1_pmc_o) !== m_pm[b]) begin
               errors++;
               $display("FAIL pmc1 state %0d: got %0d required %0d", c - 1, acs_path_1_pmc_o, m_pm[b]);
            end
         end
         checks++;
         if (sym_ready_o !== 1'b0 || dec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL run_flags cycle %0d: ready=%b dec_valid=%b required 0 0", c, sym_ready_o, dec_valid_o);
         end
         if (c == abort_cycle) begin
            init_i = 1'b1;
            @(negedge clk);
            init_i = 1'b0;
            checks++;
            if (dec_valid_o !== 1'b0 || sym_ready_o !== 1'b1 || acs_path_0_valid_o !== 1'b0) begin
               errors++;
               $display("FAIL abort: dec_valid=%b ready=%b v0=%b required 0 1 0",
                        dec_valid_o, sym_ready_o, acs_path_0_valid_o);
            end
            model_init();
            return;
         end
         @(negedge clk);
      end
      checks++;
      if (dec_valid_o !== 1'b1 || sym_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL emit_flags: dec_valid=%b ready=%b required 1 0", dec_valid_o, sym_ready_o);
      end
      checks++;
      if (dec_bits_o !== e_bits || dec_mask_o !== e_mask) begin
         errors++;
         $display("FAIL decision: bits=%b mask=%b required bits=%b mask=%b", dec_bits_o, dec_mask_o, e_bits, e_mask);
      end
      checks++;
      if (int'(best_state_o) !== e_best_state || int'(best_cost_o) !== e_best_cost) begin
         errors++;
         $display("FAIL best: state=%0d cost=%0d required state=%0d cost=%0d",
                  best_state_o, best_cost_o, e_best_state, e_best_cost);
      end
      model_commit();
      @(negedge clk);
      checks++;
      if (dec_valid_o !== 1'b0 || sym_ready_o !== 1'b1 || dec_mask_o !== e_mask) begin
         errors++;
         $display("FAIL post_emit: dec_valid=%b ready=%b mask=%b required 0 1 %b",
                  dec_valid_o, sym_ready_o, dec_mask_o, e_mask);
      end
   endtask

   task automatic do_init();
      init_i = 1'b1;
      @(negedge clk);
      init_i = 1'b0;
      model_init();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      init_i = 1'b0;
      sym_valid_i = 1'b0;
      set_bm(0);
      model_init();
      repeat (3) @(negedge clk);
      checks++;
      if (sym_ready_o !== 1'b0 || dec_valid_o !== 1'b0 || dec_bits_o !== 8'd0 || dec_mask_o !== 8'd0 ||
          best_state_o !== 3'd0 || best_cost_o !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b dv=%b bits=%h mask=%h bs=%0d bc=%0d required all 0",
                  sym_ready_o, dec_valid_o, dec_bits_o, dec_mask_o, best_state_o, best_cost_o);
      end
      checks++;
      if (acs_path_0_pmc_o !== 8'd0 || acs_path_1_pmc_o !== 8'd0 || acs_path_0_valid_o !== 1'b0 ||
          acs_path_1_valid_o !== 1'b0 || acs_state_o !== 3'd0) begin
         errors++;
         $display("FAIL reset_acs_ports: nonzero operand outputs required 0");
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (sym_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b required 1", sym_ready_o);
      end
   endtask

   task automatic test_zero_symbol(input string tag);
      set_bm(0);
      do_symbol(0);
      checks++;
      if (dec_mask_o !== 8'b0001_0001 || dec_bits_o !== 8'd0 || best_state_o !== 3'd0 || best_cost_o !== 8'd0) begin
         errors++;
         $display("FAIL %s: mask=%b bits=%b bs=%0d bc=%0d required 00010001 0 0 0",
                  tag, dec_mask_o, dec_bits_o, best_state_o, best_cost_o);
      end
   endtask

   task automatic test_tie();
      do_init();
      set_bm(0);
      repeat (3) do_symbol(0);
      set_bm(7);
      bm0[0] = 8'd5;
      bm1[0] = 8'd5;
      do_symbol(0);
      checks++;
      if (dec_bits_o[0] !== 1'b0 || best_state_o !== 3'd0 || best_cost_o !== 8'd5) begin
         errors++;
         $display("FAIL tie: sel0=%b bs=%0d bc=%0d required 0 0 5", dec_bits_o[0], best_state_o, best_cost_o);
      end
      set_bm(0);
      do_symbol(0);
   endtask

   task automatic test_normalisation();
      do_init();
      set_bm(3);
      for (int k = 1; k <= 43; k++) begin
         do_symbol(0);
         if (k == 42) begin
            checks++;
            if (best_cost_o !== 8'd126) begin
               errors++;
               $display("FAIL norm_sym42: best_cost=%0d required 126", best_cost_o);
            end
         end
         if (k == 43) begin
            checks++;
            if (best_cost_o !== 8'd1) begin
               errors++;
               $display("FAIL norm_sym43: best_cost=%0d required 1", best_cost_o);
            end
         end
      end
   endtask

   task automatic test_abort();
      set_bm(2);
      do_symbol(4);
      test_zero_symbol("abort_then_zero");
   endtask

   task automatic test_back_to_back();
      int wait_n;
      wait_n = 0;
      set_bm(1);
      while (sym_ready_o !== 1'b1 && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      sym_valid_i = 1'b1;
      for (int c = 0; c < 30; c++) begin
         checks++;
         if (sym_ready_o !== (c % 10 == 0) || dec_valid_o !== (c % 10 == 9)) begin
            errors++;
            $display("FAIL backpressure cycle %0d: ready=%b dec_valid=%b required %b %b",
                     c, sym_ready_o, dec_valid_o, (c % 10 == 0), (c % 10 == 9));
         end
         @(negedge clk);
      end
      sym_valid_i = 1'b0;
      repeat (3) begin
         model_compute();
         model_commit();
      end
      do_symbol(0);
   endtask

   task automatic test_random();
      do_init();
      for (int k = 0; k < 25; k++) begin
         for (int s = 0; s < N; s++) begin
            bm0[s] = 8'($urandom_range(0, 3));
            bm1[s] = 8'($urandom_range(0, 3));
         end
         do_symbol(($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 8)) : 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_zero_symbol("first_symbol");
      test_tie();
      test_normalisation();
      test_abort();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
